// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, one-hot phase codes,
// error codes and the sequencer state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b011101;
  localparam logic [5:0] OP_BEQ   = 6'b100000;

  localparam logic [5:0] ST_IDLE   = 6'b000000;
  localparam logic [5:0] ST_FETCH  = 6'b000001;
  localparam logic [5:0] ST_DECODE = 6'b000010;
  localparam logic [5:0] ST_EXEC   = 6'b000100;
  localparam logic [5:0] ST_MEM    = 6'b001000;
  localparam logic [5:0] ST_WB     = 6'b010000;
  localparam logic [5:0] ST_PCUPD  = 6'b100000;
  localparam logic [5:0] ST_HALT   = 6'b000000;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALT   = 3'd7
  } seq_state_e;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: op_is_legal = 1'b1;
      default:                        op_is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] state_onehot(input seq_state_e s);
    case (s)
      S_FETCH:  state_onehot = ST_FETCH;
      S_DECODE: state_onehot = ST_DECODE;
      S_EXEC:   state_onehot = ST_EXEC;
      S_MEM:    state_onehot = ST_MEM;
      S_WB:     state_onehot = ST_WB;
      S_PCUPD:  state_onehot = ST_PCUPD;
      S_HALT:   state_onehot = ST_HALT;
      default:  state_onehot = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mips_state_sequencer_mem_wait_timer.sv
// Wait-state timer for a memory master: counts unacknowledged request cycles and
// flags the cycle on which one more miss would reach TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear outside a wait, step on each missed ack.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expire only on a miss, so an ack on the final allowed cycle still wins.
  assign expire = inc && (cnt_q == LAST);

endmodule

// File: rtl/mips_state_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB/PCUPD and halts on illegal opcodes or memory timeouts.
module mips_state_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             mem_ack,
  output logic [5:0]       state,
  output logic             mem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  seq_state_e       state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wait_s;
  logic             expire_s;

  assign wait_s = (state_q == S_FETCH) || (state_q == S_MEM);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!wait_s),
    .inc    (wait_s && !mem_ack),
    .expire (expire_s)
  );

  // Next-state, opcode latch, error and retire-count logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    err_d     = err_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (expire_s) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (op_is_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      // Routing uses the latched opcode; the IR may change under us here.
      S_EXEC: begin
        case (op_q)
          OP_RTYPE:     state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ:       state_d = S_PCUPD;
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (op_q == OP_LW) state_d = S_WB;
          else               state_d = S_PCUPD;
        end else if (expire_s) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_PCUPD;
      S_PCUPD: begin
        state_d   = S_FETCH;
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 6'b000000;
      err_q     <= ERR_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign state    = state_onehot(state_q);
  assign mem_req  = wait_s;
  assign ir_write = (state_q == S_FETCH) && mem_ack;
  assign pc_write = (state_q == S_PCUPD);
  assign halted   = (state_q == S_HALT);
  assign err_code = err_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Directed-vector bench for mips_state_sequencer: each cycle drives inputs on the
// falling edge and compares outputs against hand-computed expectations.
module tb_mips_state_sequencer;

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] LW = 6'b011100;
  localparam logic [5:0] SW = 6'b011101;
  localparam logic [5:0] BQ = 6'b100000;
  localparam logic [5:0] BAD = 6'b111111;

  localparam logic [5:0] F = 6'b000001;
  localparam logic [5:0] D = 6'b000010;
  localparam logic [5:0] E = 6'b000100;
  localparam logic [5:0] M = 6'b001000;
  localparam logic [5:0] W = 6'b010000;
  localparam logic [5:0] P = 6'b100000;
  localparam logic [5:0] Z = 6'b000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  opcode;
  logic        mem_ack;
  logic [5:0]  state;
  logic        mem_req;
  logic        ir_write;
  logic        pc_write;
  logic        halted;
  logic [1:0]  err_code;
  logic [31:0] retired;

  int n_vec = 0;
  int n_bad = 0;

  mips_state_sequencer #(.TIMEOUT(15), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opcode   (opcode),
    .mem_ack  (mem_ack),
    .state    (state),
    .mem_req  (mem_req),
    .ir_write (ir_write),
    .pc_write (pc_write),
    .halted   (halted),
    .err_code (err_code),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then check outputs.
  task automatic cyc(input logic r, input logic st, input logic [5:0] op, input logic ack,
                     input logic [5:0] es, input logic emr, input logic eir, input logic epc);
    @(negedge clk);
    rst = r; start = st; opcode = op; mem_ack = ack;
    #1;
    check_vec("state", {26'd0, state}, {26'd0, es});
    check_vec("mem_req", {31'd0, mem_req}, {31'd0, emr});
    check_vec("ir_write", {31'd0, ir_write}, {31'd0, eir});
    check_vec("pc_write", {31'd0, pc_write}, {31'd0, epc});
  endtask

  task automatic stat(input logic eh, input logic [1:0] ee, input logic [31:0] eret);
    check_vec("halted", {31'd0, halted}, {31'd0, eh});
    check_vec("err_code", {30'd0, err_code}, {30'd0, ee});
    check_vec("retired", retired, eret);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 6'b000000; mem_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, then start with stray ack in IDLE (ignored).
    cyc(1'b0, 1'b1, RT, 1'b1, Z, 1'b0, 1'b0, 1'b0);
    stat(1'b0, 2'b00, 32'd0);

    // RTYPE, zero wait.
    cyc(1'b0, 1'b0, RT, 1'b1, F, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, E, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, W, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, P, 1'b0, 1'b0, 1'b1);
    stat(1'b0, 2'b00, 32'd0);

    // LW: 3 fetch waits, 2 mem waits.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, RT, 1'b0, F, 1'b1, 1'b0, 1'b0);
    stat(1'b0, 2'b00, 32'd1);
    cyc(1'b0, 1'b0, RT, 1'b1, F, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, LW, 1'b1, D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, E, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, RT, 1'b0, M, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, M, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, W, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, P, 1'b0, 1'b0, 1'b1);

    // SW, BEQ, LW back to back; live opcode changed during EXEC.
    cyc(1'b0, 1'b0, RT, 1'b1, F, 1'b1, 1'b1, 1'b0);
    stat(1'b0, 2'b00, 32'd2);
    cyc(1'b0, 1'b0, SW, 1'b1, D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, E, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, M, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, P, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, RT, 1'b1, F, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, BQ, 1'b1, D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, LW, 1'b1, E, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, LW, 1'b1, P, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, RT, 1'b1, F, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, LW, 1'b1, D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, SW, 1'b1, E, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, M, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, W, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, P, 1'b0, 1'b0, 1'b1);

    // Fetch: 14 misses then ack on the 15th cycle proceeds.
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, RT, 1'b0, F, 1'b1, 1'b0, 1'b0);
    stat(1'b0, 2'b00, 32'd5);
    cyc(1'b0, 1'b0, RT, 1'b1, F, 1'b1, 1'b1, 1'b0);

    // Illegal opcode halts after DECODE; start is ignored.
    cyc(1'b0, 1'b0, BAD, 1'b1, D, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, RT, 1'b1, Z, 1'b0, 1'b0, 1'b0);
    stat(1'b1, 2'b01, 32'd5);

    // Reset out of HALT, then 15 fetch misses time out.
    cyc(1'b1, 1'b0, RT, 1'b0, Z, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, RT, 1'b0, Z, 1'b0, 1'b0, 1'b0);
    stat(1'b0, 2'b00, 32'd0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, RT, 1'b0, F, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, Z, 1'b0, 1'b0, 1'b0);
    stat(1'b1, 2'b10, 32'd0);

    // Reset, one BEQ, then reset in the middle of a LW memory wait.
    cyc(1'b1, 1'b0, RT, 1'b0, Z, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, RT, 1'b0, Z, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, F, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, BQ, 1'b1, D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, E, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, P, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, RT, 1'b1, F, 1'b1, 1'b1, 1'b0);
    stat(1'b0, 2'b00, 32'd1);
    cyc(1'b0, 1'b0, LW, 1'b1, D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b0, E, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b0, M, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, RT, 1'b0, M, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, RT, 1'b1, Z, 1'b0, 1'b0, 1'b0);
    stat(1'b0, 2'b00, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
